// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and a colour type, used by
// the timing generator and by the drawing blocks.
package vga_pkg;

    localparam int CLK_DIV  = 4;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    // Half-open window test [lo, hi) on a 16-bit coordinate.
    function automatic logic in_window(input logic [15:0] value,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-enable divider: pix_tick is high for one clk out of every CLK_DIV.
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divider;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            divider <= '0;
        else if (divider == LAST)
            divider <= '0;
        else
            divider <= divider + DW'(1);
    end

    // Gated by reset so the tick stays low in reset even when CLK_DIV is 1.
    assign pix_tick = (divider == LAST) && !reset;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, registered sync/blank decode and
// the colour gate that blanks the connector outside the visible area.
module vga_timing
    import vga_pkg::rgb_t;
    import vga_pkg::in_window;
#(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  r_red_in,
    input  logic [3:0]  r_green_in,
    input  logic [3:0]  r_blue_in,
    output logic [15:0] Hcount,
    output logic [15:0] Vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue
);

    localparam logic [15:0] H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_VISIBLE  = 16'(H_ACTIVE);
    localparam logic [15:0] V_VISIBLE  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_next;
    logic [15:0] v_next;
    rgb_t        pixel_in;
    rgb_t        pixel_out;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (pix_tick)
    );

    // Compare against the last value before incrementing so no count ever
    // exceeds its total minus one.
    always_comb begin
        h_next = Hcount;
        v_next = Vcount;
        if (pix_tick) begin
            if (Hcount == H_LAST) begin
                h_next = '0;
                v_next = (Vcount == V_LAST) ? 16'd0 : Vcount + 16'd1;
            end else begin
                h_next = Hcount + 16'd1;
            end
        end
    end

    // Flags decode the next counts so they change on the same edge as the
    // counters they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Hcount      <= '0;
            Vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            Hcount      <= h_next;
            Vcount      <= v_next;
            hsync       <= !in_window(h_next, HS_START, HS_END);
            vsync       <= !in_window(v_next, VS_START, VS_END);
            video_on    <= (h_next < H_VISIBLE) && (v_next < V_VISIBLE);
            frame_start <= pix_tick && (h_next == 16'd0) && (v_next == 16'd0);
        end
    end

    assign pixel_in  = {r_red_in, r_green_in, r_blue_in};
    assign pixel_out = video_on ? pixel_in : '0;
    assign vga_red   = pixel_out.red;
    assign vga_green = pixel_out.green;
    assign vga_blue  = pixel_out.blue;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a shrunken raster so whole frames fit in a short
// run; every clk is compared with a model built from clks-since-reset.
module tb_vga_timing;

    localparam int CD = 4;
    localparam int HA = 20, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        reset;
    logic [3:0]  r_red_in, r_green_in, r_blue_in;
    logic [15:0] Hcount, Vcount;
    logic        hsync, vsync, video_on, pix_tick, frame_start;
    logic [3:0]  vga_red, vga_green, vga_blue;

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit all_white = 1'b0;

    vga_timing #(
        .CLK_DIV (CD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .r_red_in   (r_red_in),
        .r_green_in (r_green_in),
        .r_blue_in  (r_blue_in),
        .Hcount     (Hcount),
        .Vcount     (Vcount),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pix_tick   (pix_tick),
        .frame_start(frame_start),
        .vga_red    (vga_red),
        .vga_green  (vga_green),
        .vga_blue   (vga_blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_h"},     Hcount,      16'd0);
        check({tag, "_v"},     Vcount,      16'd0);
        check({tag, "_hsync"}, 16'(hsync),  16'd1);
        check({tag, "_vsync"}, 16'(vsync),  16'd1);
        check({tag, "_von"},   16'(video_on), 16'd1);
        check({tag, "_tick"},  16'(pix_tick), 16'd0);
        check({tag, "_fs"},    16'(frame_start), 16'd0);
        check({tag, "_red"},   16'(vga_red), 16'(r_red_in));
    endtask

    // Model: k clks after reset release, k/CD pixels have elapsed.
    task automatic check_output();
        int p, h, v;
        bit e_tick, e_fs, e_hs, e_vs, e_von;
        p      = k / CD;
        h      = p % HT;
        v      = (p / HT) % VT;
        e_tick = (k % CD) == CD - 1;
        e_fs   = (p > 0) && (p % FRAME == 0) && (k % CD == 0);
        e_hs   = !(h >= HA + HF && h < HA + HF + HS);
        e_vs   = !(v >= VA + VF && v < VA + VF + VS);
        e_von  = (h < HA) && (v < VA);
        check("hcount",  Hcount,            16'(h));
        check("vcount",  Vcount,            16'(v));
        check("pix_tick", 16'(pix_tick),    16'(e_tick));
        check("frame_start", 16'(frame_start), 16'(e_fs));
        check("hsync",   16'(hsync),        16'(e_hs));
        check("vsync",   16'(vsync),        16'(e_vs));
        check("video_on", 16'(video_on),    16'(e_von));
        check("vga_red",   16'(vga_red),   e_von ? 16'(r_red_in)   : 16'd0);
        check("vga_green", 16'(vga_green), e_von ? 16'(r_green_in) : 16'd0);
        check("vga_blue",  16'(vga_blue),  e_von ? 16'(r_blue_in)  : 16'd0);
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        k++;
        #1;
        if (all_white) begin
            r_red_in = 4'hF; r_green_in = 4'hF; r_blue_in = 4'hF;
        end else begin
            r_red_in   = 4'($urandom_range(0, 15));
            r_green_in = 4'($urandom_range(0, 15));
            r_blue_in  = 4'($urandom_range(0, 15));
        end
        #1;
        check_output();
    endtask

    initial begin
        int ticks, fs_count, hs_low, stop_at;
        reset = 1'b1;
        r_red_in = 4'h3; r_green_in = 4'h5; r_blue_in = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset = 1'b0;
        k = 0;

        $display("[TB] frame 1: random colours");
        ticks = 0; fs_count = 0; hs_low = 0;
        for (int i = 0; i < CD * FRAME; i++) begin
            apply_stimulus();
            if (pix_tick) ticks++;
            if (frame_start) fs_count++;
            if (i < CD * HT && !hsync) hs_low++;
        end
        check("ticks_per_frame", 16'(ticks), 16'(FRAME));
        check("frame_starts", 16'(fs_count), 16'd1);
        check("hsync_low_clks", 16'(hs_low), 16'(HS * CD));

        $display("[TB] frame 2: white input");
        all_white = 1'b1;
        for (int i = 0; i < CD * FRAME; i++) apply_stimulus();
        all_white = 1'b0;

        $display("[TB] frame 3: asynchronous reset mid-frame");
        stop_at = int'($urandom_range(CD * HT * 2, CD * FRAME - 1));
        for (int i = 0; i < stop_at; i++) apply_stimulus();
        #2;
        reset = 1'b1;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        check_reset("reset_hold");
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < CD * HT * 3; i++) apply_stimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
